addsub_chunked: RTL and testbench
=================================

# addsub_chunked

Parametrised, multi-cycle signed/unsigned adder-subtractor. It processes `CHUNK` bits per clock with a registered carry between chunks, and generalises the fixed 16-bit combinational adder-subtractor to any width. It adds valid/ready handshakes on both sides and registered flags. It sits in the datapath as the shared arithmetic unit for sequenced expressions such as 3a − 2b, issued one operation at a time.

## Interface
- `WIDTH`, 16: operand and result width. Must be ≥ 2 and a multiple of `CHUNK`.
- `CHUNK`, 4: bits added per cycle. `N = WIDTH/CHUNK` is the compute cycle count.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and mode are presented.
- `in_ready`  out  1  block can accept an operation.
- `input1`  in  WIDTH  operand A.
- `input2`  in  WIDTH  operand B.
- `I`  in  1  0 = A+B, 1 = A−B (computed as A + ~B + 1).
- `S`  in  1  1 = signed (two's complement) interpretation, 0 = unsigned.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  result.
- `outc`  out  1  raw carry out of the MSB.
- `overflow`  out  1  signed overflow; only when S=1.
- `borrow`  out  1  unsigned subtract underflow, `I & ~S & ~outc`.
- `isValid`  out  1  `overflow | borrow`. Legacy name; high means the result is out of range.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready`, latch `input1`, `input2 ^ {WIDTH{I}}`, `I`, `S`.
  - Set carry register = `I` and chunk index = 0, then go to RUN.
- RUN: each cycle, add chunk `idx` of A and B' plus the carry register.
  - Write the `CHUNK` sum bits into `sum[idx*CHUNK +: CHUNK]`.
  - Store the carry out in the carry register and increment `idx`.
  - On the last chunk (`idx == N-1`), compute the flags and go to DONE.
- Flags are computed on the final chunk:
  - `outc` = final carry.
  - `overflow` = `S & (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1])`.
  - `borrow` and `isValid` as defined in the Interface.
- DONE: `out_valid`=1. `sum` and all flags hold stable while `out_ready`=0. On `out_ready`=1, go to IDLE.
- `in_ready` is 0 in RUN and DONE. Operands change outside IDLE are ignored.
- Inputs are latched at acceptance; later changes to `input1`/`input2`/`I`/`S` do not affect the operation.
- Arithmetic is modulo 2^WIDTH. No width extension; `sum` is exactly WIDTH bits.
- Reset (any state, including mid-RUN): the FSM goes to IDLE and the in-flight operation is discarded.
  - Reset values: `in_ready`=1 after release, `out_valid`=0, `sum`=0, `outc`=0, `overflow`=0, `borrow`=0, `isValid`=0.
  - The asserted value of `in_ready` during reset is don't-care. Benches sample it only after release.

## Timing
- Accept at edge k. Chunks are processed at edges k+1 … k+N. `out_valid` is high after edge k+N.
- Latency is N cycles (4 for default parameters). With `CHUNK == WIDTH`, latency is 1.
- Result consumed at edge m (`out_valid & out_ready`): `out_valid`=0 and `in_ready`=1 after edge m. The next acceptance occurs no earlier than edge m+1.
- Throughput is one operation per N+2 cycles with `out_ready` held high.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid`/`out_ready`.
- `in_ready` and `out_valid` are never high in the same cycle.

## Configuration
- `ADDSUB_SATURATE_EN` defined: when the operation goes out of range, the final-chunk update replaces `sum` with a clamped value.
  - Signed overflow: `sum` = `A[W-1]` ? most-negative : most-positive.
  - Unsigned add with `outc`=1: `sum` = all ones.
  - Unsigned subtract with `borrow`=1: `sum` = 0.
  - Flags still report the raw condition. Latency is unchanged.
- Not defined: `sum` is always the wrapped modulo result.

## Test plan
(WIDTH=16, CHUNK=4 unless stated.)
- Unsigned add: 0x0005 + 0x0003, S=0, I=0 -> `sum`=0x0008, all flags 0, `out_valid` exactly 4 cycles after accept.
- Signed overflow: 0x7FFF + 0x0001, S=1, I=0 -> `sum`=0x8000, `overflow`=1, `isValid`=1. With `ADDSUB_SATURATE_EN`: `sum`=0x7FFF.
- Unsigned underflow: 0x0003 − 0x0005, S=0, I=1 -> `sum`=0xFFFE, `outc`=0, `borrow`=1. With the macro: `sum`=0x0000.
- Signed subtract: 0x8000 − 0x0001, S=1, I=1 -> `sum`=0x7FFF, `overflow`=1. With the macro: 0x8000. Also 3·0x0007 − 2·0x0004 as a four-operation sequence -> 0x000D.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE, toggling inputs and `in_valid` -> `sum`/flags stable, `in_ready`=0, no second accept. Release -> IDLE next cycle.
- Reset mid-RUN: assert `rst` after chunk 2 -> outputs immediately at reset values, `out_valid` never pulses. A new op after release completes normally. Repeat the first scenario with WIDTH=8, CHUNK=8 -> 1-cycle latency.

Source files
------------

// File: rtl/addsub_chunked.sv
// Multi-cycle adder-subtractor: CHUNK bits per cycle with a registered carry,
// valid/ready handshakes, registered flags. Optional macro: ADDSUB_SATURATE_EN.
module addsub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             I,
    input  logic             S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             overflow,
    output logic             borrow,
    output logic             isValid
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              i_q, i_d;
    logic              s_q, s_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              outc_q, outc_d;
    logic              ovf_q, ovf_d;
    logic              brw_q, brw_d;
    logic              isv_q, isv_d;

    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK:0]    chunk_sum_s;

    // Current chunk slice of the latched operands and its carry-extended sum.
    always_comb begin
        a_chunk_s   = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk_s   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state, datapath and flag computation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        s_d     = s_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        outc_d  = outc_q;
        ovf_d   = ovf_q;
        brw_d   = brw_q;
        isv_d   = isv_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // B is pre-inverted so subtraction is A + ~B + 1 via carry-in.
                    a_d     = input1;
                    b_d     = input2 ^ {WIDTH{I}};
                    i_d     = I;
                    s_d     = S;
                    carry_d = I;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
                carry_d                     = chunk_sum_s[CHUNK];
                if (idx_q == LAST_IDX) begin
                    outc_d  = chunk_sum_s[CHUNK];
                    ovf_d   = s_q & (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                              (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    brw_d   = i_q & ~s_q & ~chunk_sum_s[CHUNK];
                    isv_d   = ovf_d | brw_d;
                    state_d = DONE;
`ifdef ADDSUB_SATURATE_EN
                    // Clamp on out-of-range; flags keep reporting the raw result.
                    if (ovf_d) begin
                        sum_d = a_q[WIDTH-1] ? MOST_NEG : MOST_POS;
                    end else if (~s_q & ~i_q & chunk_sum_s[CHUNK]) begin
                        sum_d = {WIDTH{1'b1}};
                    end else if (brw_d) begin
                        sum_d = {WIDTH{1'b0}};
                    end else begin
                        sum_d = sum_d;
                    end
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= 1'b0;
            s_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            outc_q  <= 1'b0;
            ovf_q   <= 1'b0;
            brw_q   <= 1'b0;
            isv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            outc_q  <= outc_d;
            ovf_q   <= ovf_d;
            brw_q   <= brw_d;
            isv_q   <= isv_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign outc      = outc_q;
    assign overflow  = ovf_q;
    assign borrow    = brw_q;
    assign isValid   = isv_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// Scoreboard bench for addsub_chunked: 16/4 instance plus an 8/8 single-cycle instance.
module tb_addsub_chunked;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv16, ir16, i16, s16, ov16, or16, c16, o16, b16, v16;
    logic [15:0] a16, bb16, sum16;
    logic        iv8, ir8, i8, s8, ov8, or8, c8, o8, b8, v8;
    logic [7:0]  a8, bb8, sum8;

    addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .input1(a16), .input2(bb16), .I(i16), .S(s16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16), .outc(c16),
        .overflow(o16), .borrow(b16), .isValid(v16)
    );

    addsub_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .input1(a8), .input2(bb8), .I(i8), .S(s8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .outc(c8),
        .overflow(o8), .borrow(b8), .isValid(v8)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        o;
        logic        b;
        logic        v;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] pick(input logic [15:0] wrapped, input logic [15:0] clamped);
`ifdef ADDSUB_SATURATE_EN
        return clamped;
`else
        return wrapped;
`endif
    endfunction

    // Monitor for the 16-bit instance: pop and compare on every handshake.
    always @(negedge clk) begin
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) begin
                check("unexpected_out16", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("sum16", sum16, e16.sum);
                check("outc16", c16, e16.c);
                check("ovf16", o16, e16.o);
                check("borrow16", b16, e16.b);
                check("isvalid16", v16, e16.v);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                check("unexpected_out8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("sum8", sum8, e8.sum);
                check("outc8", c8, e8.c);
                check("ovf8", o8, e8.o);
                check("borrow8", b8, e8.b);
                check("isvalid8", v8, e8.v);
            end
        end
    end

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic iv, input logic sv,
                        input logic [15:0] es, input logic ec, input logic eo, input logic eb);
        int n;
        n = 0;
        while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
        check("ready_wait16", ir16, 1'b1);
        a16 = av; bb16 = bv; i16 = iv; s16 = sv; iv16 = 1'b1;
        q16.push_back({es, ec, eo, eb, eo | eb});
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 50) begin @(posedge clk); #1; n++; end
        check("latency16", n, 32'd4);
        @(posedge clk); #1;
        check("idle_after16", {ov16, ir16}, 2'b01);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic iv, input logic sv,
                       input logic [7:0] es, input logic ec, input logic eo, input logic eb);
        int n;
        n = 0;
        while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
        check("ready_wait8", ir8, 1'b1);
        a8 = av; bb8 = bv; i8 = iv; s8 = sv; iv8 = 1'b1;
        q8.push_back({8'h00, es, ec, eo, eb, eo | eb});
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin @(posedge clk); #1; n++; end
        check("latency8", n, 32'd1);
        @(posedge clk); #1;
        check("idle_after8", {ov8, ir8}, 2'b01);
    endtask

    initial begin
        int n;
        logic seen;
        iv16 = 1'b0; a16 = 16'h0; bb16 = 16'h0; i16 = 1'b0; s16 = 1'b0; or16 = 1'b1;
        iv8  = 1'b0; a8  = 8'h0;  bb8  = 8'h0;  i8  = 1'b0; s8  = 1'b0; or8  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outvalid", ov16, 1'b0);
        check("rst_sum", sum16, 16'h0000);
        check("rst_flags", {c16, o16, b16, v16}, 4'b0000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_inready", ir16, 1'b1);

        op16(16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b1, pick(16'h8000, 16'h7FFF), 1'b0, 1'b1, 1'b0);
        op16(16'h0003, 16'h0005, 1'b1, 1'b0, pick(16'hFFFE, 16'h0000), 1'b0, 1'b0, 1'b1);
        op16(16'h8000, 16'h0001, 1'b1, 1'b1, pick(16'h7FFF, 16'h8000), 1'b1, 1'b1, 1'b0);
        op16(16'hFFFF, 16'h0002, 1'b0, 1'b0, pick(16'h0001, 16'hFFFF), 1'b1, 1'b0, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        // 3a - 2b with a=7, b=4
        op16(16'h0007, 16'h0007, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0);
        op16(16'h000E, 16'h0007, 1'b0, 1'b1, 16'h0015, 1'b0, 1'b0, 1'b0);
        op16(16'h0004, 16'h0004, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
        op16(16'h0015, 16'h0008, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold DONE while inputs churn.
        or16 = 1'b0;
        a16 = 16'h1234; bb16 = 16'h1111; i16 = 1'b0; s16 = 1'b0; iv16 = 1'b1;
        q16.push_back({16'h2345, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_latency", n, 32'd4);
        for (int k = 0; k < 5; k++) begin
            iv16 = 1'b1; a16 = ~a16; bb16 = bb16 + 16'h0101; i16 = ~i16; s16 = ~s16;
            @(posedge clk); #1;
            check("bp_sum", sum16, 16'h2345);
            check("bp_flags", {c16, o16, b16, v16}, 4'b0000);
            check("bp_hs", {ov16, ir16}, 2'b10);
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {ov16, ir16}, 2'b01);
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen = seen | ov16; end
        check("bp_no_second", seen, 1'b0);

        // Reset in the middle of RUN.
        a16 = 16'h1111; bb16 = 16'h2222; i16 = 1'b0; s16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_sum", sum16, 16'h0000);
        check("midrst_flags", {ov16, c16, o16, b16, v16}, 5'b00000);
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen = seen | ov16; end
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen = seen | ov16; end
        check("midrst_no_pulse", seen, 1'b0);
        check("midrst_ready", ir16, 1'b1);
        op16(16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);

        // Single-chunk instance.
        op8(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 1'b1, pick(16'h0080, 16'h007F) & 8'hFF, 1'b0, 1'b1, 1'b0);
        op8(8'h03, 8'h05, 1'b1, 1'b0, pick(16'h00FE, 16'h0000) & 8'hFF, 1'b0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check("q16_drained", q16.size(), 32'd0);
        check("q8_drained", q8.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
